// File: rtl/mdu_sched.sv
// Multiply/divide scheduler for the E stage. It runs one MDU op for a fixed latency,
// owns HI/LO and requests a D-stage stall while a following MDU op would conflict.
module mdu_sched #(
  parameter int unsigned MUL_CYCLES = 5,
  parameter int unsigned DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  input  logic        d_is_md,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] md_out,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        ovr_err
);

  localparam logic [3:0] MUL_CNT = 4'(MUL_CYCLES);
  localparam logic [3:0] DIV_CNT = 4'(DIV_CYCLES);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic [31:0] hi_q, lo_q;
  logic [31:0] phi_q, plo_q;
  logic        ovr_q;

  logic [31:0] pend_hi_d, pend_lo_d;
  logic        is_long_op;
  logic [63:0] prod_s, prod_u;
  logic [31:0] mag_a, mag_b, dvs_s, dvs_u;
  logic [31:0] q_u, r_u, q_m, r_m, q_s, r_s;

  assign is_long_op = (op >= OP_MULT) && (op <= OP_DIVU);

  // Signed ops work on magnitudes; a zero divisor is replaced by 1 only to keep the
  // dividers defined, the result is then discarded in favour of the current HI/LO.
  always_comb begin
    prod_s = {{32{rs[31]}}, rs} * {{32{rt[31]}}, rt};
    prod_u = {32'b0, rs} * {32'b0, rt};
    mag_a  = rs[31] ? (32'd0 - rs) : rs;
    mag_b  = rt[31] ? (32'd0 - rt) : rt;
    dvs_s  = (rt == 32'd0) ? 32'd1 : mag_b;
    dvs_u  = (rt == 32'd0) ? 32'd1 : rt;
    q_u    = rs / dvs_u;
    r_u    = rs % dvs_u;
    q_m    = mag_a / dvs_s;
    r_m    = mag_a % dvs_s;
    q_s    = (rs[31] ^ rt[31]) ? (32'd0 - q_m) : q_m;
    r_s    = rs[31] ? (32'd0 - r_m) : r_m;
    pend_hi_d = hi_q;
    pend_lo_d = lo_q;
    case (op)
      OP_MULT:  begin pend_hi_d = prod_s[63:32]; pend_lo_d = prod_s[31:0]; end
      OP_MULTU: begin pend_hi_d = prod_u[63:32]; pend_lo_d = prod_u[31:0]; end
      OP_DIV: if (rt != 32'd0) begin pend_hi_d = r_s; pend_lo_d = q_s; end
      OP_DIVU: if (rt != 32'd0) begin pend_hi_d = r_u; pend_lo_d = q_u; end
      default: ;
    endcase
  end

  // The two-state FSM is observable directly through busy (busy == RUN).
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      phi_q   <= 32'd0;
      plo_q   <= 32'd0;
      ovr_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (is_long_op) begin
              phi_q   <= pend_hi_d;
              plo_q   <= pend_lo_d;
              cnt_q   <= (op <= OP_MULTU) ? MUL_CNT : DIV_CNT;
              state_q <= S_RUN;
            end else if (op == OP_MTHI) begin
              hi_q <= rs;
            end else if (op == OP_MTLO) begin
              lo_q <= rs;
            end
          end
        end
        S_RUN: begin
          if (start) ovr_q <= 1'b1;
          if (cnt_q == 4'd1) begin
            hi_q    <= phi_q;
            lo_q    <= plo_q;
            cnt_q   <= 4'd0;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy      = (state_q == S_RUN);
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign ovr_err   = ovr_q;
  assign stall_req = d_is_md & (busy | (start & is_long_op));
  assign md_out    = (op == OP_MFHI) ? hi_q : ((op == OP_MFLO) ? lo_q : 32'd0);

endmodule

// File: tb/tb_mdu_sched.sv
// Directed bench for mdu_sched: stimulus schedules expected values per cycle into a
// queue, and a negedge monitor compares whatever is due in the current cycle.
module tb_mdu_sched;

  localparam int SEL_BUSY = 0, SEL_STALL = 1, SEL_MD = 2, SEL_HI = 3, SEL_LO = 4, SEL_OVR = 5;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  op = 4'd0;
  logic [31:0] rs = 32'd0, rt = 32'd0;
  logic        d_is_md = 1'b0;
  logic        busy, stall_req, ovr_err;
  logic [31:0] md_out, hi, lo;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  logic [31:0] exp_q[$];
  int          cyc_q[$];
  int          sel_q[$];

  mdu_sched #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .rs(rs), .rt(rt),
    .d_is_md(d_is_md), .busy(busy), .stall_req(stall_req), .md_out(md_out),
    .hi(hi), .lo(lo), .ovr_err(ovr_err)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] pick(input int sel);
    case (sel)
      SEL_BUSY:  pick = {31'd0, busy};
      SEL_STALL: pick = {31'd0, stall_req};
      SEL_MD:    pick = md_out;
      SEL_HI:    pick = hi;
      SEL_LO:    pick = lo;
      default:   pick = {31'd0, ovr_err};
    endcase
  endfunction

  function automatic string sel_name(input int sel);
    case (sel)
      SEL_BUSY:  sel_name = "busy";
      SEL_STALL: sel_name = "stall_req";
      SEL_MD:    sel_name = "md_out";
      SEL_HI:    sel_name = "hi";
      SEL_LO:    sel_name = "lo";
      default:   sel_name = "ovr_err";
    endcase
  endfunction

  // scoreboard monitor
  always @(negedge clk) begin
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (cyc_q[i] <= cyc) begin
        logic [31:0] act;
        act = pick(sel_q[i]);
        n_checks++;
        if (cyc_q[i] < cyc || act !== exp_q[i]) begin
          n_fail++;
          $display("FAIL %s @cycle %0d: actual=%h required=%h", sel_name(sel_q[i]),
                   cyc_q[i], act, exp_q[i]);
        end
        exp_q.delete(i);
        cyc_q.delete(i);
        sel_q.delete(i);
      end
    end
  end

  // driver tasks
  task automatic expect_at(input int at, input int sel, input logic [31:0] v);
    exp_q.push_back(v);
    cyc_q.push_back(at);
    sel_q.push_back(sel);
  endtask

  task automatic drv(input logic s, input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    start = s;
    op    = o;
    rs    = a;
    rt    = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    op    = 4'd0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drv(1'b0, 4'd0, 32'd0, 32'd0);
  endtask

  task automatic check_div(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] e_hi, input logic [31:0] e_lo,
                           input logic [31:0] old_lo);
    int c;
    c = cyc;
    for (int k = 1; k <= 10; k++) expect_at(c + k, SEL_BUSY, 32'd1);
    expect_at(c + 10, SEL_LO, old_lo);
    expect_at(c + 11, SEL_BUSY, 32'd0);
    expect_at(c + 11, SEL_HI, e_hi);
    expect_at(c + 11, SEL_LO, e_lo);
    drv(1'b1, o, a, b);
    idle(11);
  endtask

  initial begin : stim
    int c;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    c = cyc;
    expect_at(c, SEL_BUSY, 32'd0);
    expect_at(c, SEL_HI, 32'd0);
    expect_at(c, SEL_LO, 32'd0);
    expect_at(c, SEL_OVR, 32'd0);
    expect_at(c, SEL_STALL, 32'd0);
    expect_at(c, SEL_MD, 32'd0);
    idle(1);

    // mult -2*3 with a D-stage MDU op waiting the whole time
    d_is_md = 1'b1;
    c = cyc;
    expect_at(c, SEL_STALL, 32'd1);
    for (int k = 1; k <= 5; k++) begin
      expect_at(c + k, SEL_BUSY, 32'd1);
      expect_at(c + k, SEL_STALL, 32'd1);
    end
    expect_at(c + 3, SEL_MD, 32'd0);
    expect_at(c + 5, SEL_HI, 32'd0);
    expect_at(c + 6, SEL_BUSY, 32'd0);
    expect_at(c + 6, SEL_STALL, 32'd0);
    expect_at(c + 6, SEL_HI, 32'hFFFF_FFFF);
    expect_at(c + 6, SEL_LO, 32'hFFFF_FFFA);
    expect_at(c + 6, SEL_MD, 32'hFFFF_FFFF);
    expect_at(c + 6, SEL_OVR, 32'd0);
    drv(1'b1, 4'd1, 32'hFFFF_FFFE, 32'd3);
    idle(2);
    drv(1'b0, 4'd6, 32'd0, 32'd0);
    idle(2);
    drv(1'b1, 4'd5, 32'd0, 32'd0);
    d_is_md = 1'b0;

    // multu max*max, no D-stage MDU op so never a stall
    c = cyc;
    for (int k = 0; k <= 6; k++) expect_at(c + k, SEL_STALL, 32'd0);
    for (int k = 1; k <= 5; k++) expect_at(c + k, SEL_BUSY, 32'd1);
    expect_at(c + 6, SEL_BUSY, 32'd0);
    expect_at(c + 6, SEL_HI, 32'hFFFF_FFFE);
    expect_at(c + 6, SEL_LO, 32'h0000_0001);
    drv(1'b1, 4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    idle(6);

    // signed divides, including the most-negative / -1 corner
    check_div(4'd3, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'h0000_0001);
    check_div(4'd3, 32'd100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFF2, 32'hFFFF_FFFD);
    check_div(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 32'hFFFF_FFF2);

    // mthi, then divu by zero keeps HI/LO
    c = cyc;
    expect_at(c + 1, SEL_HI, 32'hAAAA_5555);
    expect_at(c + 1, SEL_LO, 32'h8000_0000);
    expect_at(c + 1, SEL_BUSY, 32'd0);
    drv(1'b1, 4'd7, 32'hAAAA_5555, 32'd0);
    idle(1);
    drv(1'b1, 4'd7, 32'h11, 32'd0);
    drv(1'b1, 4'd8, 32'h22, 32'd0);
    check_div(4'd4, 32'd5, 32'd0, 32'h11, 32'h22, 32'h22);
    check_div(4'd4, 32'd100, 32'd7, 32'd2, 32'd14, 32'h22);

    // overrun: a second mult during RUN is ignored and flags ovr_err
    c = cyc;
    expect_at(c + 2, SEL_OVR, 32'd0);
    expect_at(c + 3, SEL_OVR, 32'd1);
    expect_at(c + 5, SEL_BUSY, 32'd1);
    expect_at(c + 6, SEL_BUSY, 32'd0);
    expect_at(c + 6, SEL_HI, 32'd0);
    expect_at(c + 6, SEL_LO, 32'd42);
    expect_at(c + 6, SEL_OVR, 32'd1);
    expect_at(c + 7, SEL_BUSY, 32'd0);
    drv(1'b1, 4'd1, 32'd6, 32'd7);
    idle(1);
    drv(1'b1, 4'd1, 32'd100, 32'd100);
    idle(5);

    // reset in the 4th busy cycle of a div discards the pending result
    c = cyc;
    for (int k = 1; k <= 4; k++) expect_at(c + k, SEL_BUSY, 32'd1);
    expect_at(c + 4, SEL_LO, 32'd42);
    expect_at(c + 5, SEL_BUSY, 32'd0);
    expect_at(c + 5, SEL_HI, 32'd0);
    expect_at(c + 5, SEL_LO, 32'd0);
    expect_at(c + 5, SEL_OVR, 32'd0);
    expect_at(c + 12, SEL_BUSY, 32'd0);
    expect_at(c + 12, SEL_HI, 32'd0);
    expect_at(c + 12, SEL_LO, 32'd0);
    drv(1'b1, 4'd3, 32'd100, 32'd7);
    idle(3);
    reset = 1'b0;
    idle(1);
    reset = 1'b1;
    idle(8);

    for (int k = 0; k < 50 && exp_q.size() > 0; k++) @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      n_fail += exp_q.size();
      $display("FAIL drain: actual=%0d pending checks required=0", exp_q.size());
    end

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mdu_sched.md
Name: mdu_sched

Overview:
Multi-cycle scheduler for the multiply/divide resource in the E stage of the 5-stage pipeline.
- Accepts one MDU operation per issue and runs it for a fixed latency, with busy tracking.
- Owns and commits the HI/LO registers.
- Raises a stall request toward the D stage while any MDU instruction there would conflict with an in-flight operation.
- Replaces ad-hoc busy/start glue with one sequenced controller.

Parameters:
MUL_CYCLES, 5, cycles busy is held for mult/multu (legal range 1..15)
DIV_CYCLES, 10, cycles busy is held for div/divu (legal range 1..15)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-low; reset==0 at a rising edge clears all state
start  input  1  E-stage issue strobe, valid for one cycle per instruction
op  input  4  E-stage operation: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo; 9-15 treated as none
rs  input  32  forwarded rs operand (E stage)
rt  input  32  forwarded rt operand (E stage)
d_is_md  input  1  D-stage instruction is any MDU op (1..8)
busy  output  1  multi-cycle operation in flight
stall_req  output  1  stall D stage / freeze F and D, bubble E
md_out  output  32  mfhi/mflo read data for the E->M register
hi  output  32  committed HI
lo  output  32  committed LO
ovr_err  output  1  sticky: start was received while busy

Behaviour:
Reset:
- When reset==0 at a rising edge: state=IDLE, counter=0, hi=0, lo=0, pending regs=0, busy=0, ovr_err=0.
- Reset overrides any operation in flight. The pending result is discarded and nothing is committed.

States:
- IDLE: busy=0.
- RUN: busy=1, 4-bit down-counter cnt.

IDLE with start=1:
- op 1-4 latches the pending result and loads cnt=MUL_CYCLES (ops 1-2) or DIV_CYCLES (ops 3-4), then goes to RUN.
- op 7 (mthi) writes hi=rs at that edge. op 8 (mtlo) writes lo=rs at that edge. Both stay in IDLE.
- op 5/6, 0, 9-15: no state change.

Pending result, computed from rs/rt at the issue edge:
- mult: signed 64-bit product. multu: unsigned product. {HI,LO}={product[63:32],product[31:0]}.
- div: LO=signed quotient, HI=signed remainder, truncation toward zero, remainder takes the sign of the dividend. divu: unsigned.
- 0x80000000 div 0xFFFFFFFF: LO=0x80000000, HI=0.
- rt==0 for div/divu: the pending value is the current hi/lo, so HI/LO are unchanged after commit. Busy still lasts the full DIV_CYCLES.

RUN:
- cnt decrements each cycle.
- On the edge where cnt==1: hi/lo <= pending, state=IDLE, busy falls.
- Timing: issue edge at cycle T. busy=1 during T+1..T+N, where N=MUL_CYCLES or DIV_CYCLES. New hi/lo are visible and busy=0 from T+N+1.

start=1 while busy:
- The op is ignored (no latch, no hi/lo write) and ovr_err sets until reset.
- A correct pipeline never does this because of stall_req.

md_out (combinational):
- op==5 gives hi, op==6 gives lo, otherwise 0.
- Reads the committed registers only; there is no bypass of the pending result.

stall_req (combinational):
- stall_req = d_is_md & (busy | (start & op in 1..4)).
- mthi/mtlo in E do not stall D.
- stall_req is 0 in the cycle busy falls, so a following mfhi issues and reads the new value.

Same-edge writes: an mthi/mtlo can only occur in IDLE, so there is no same-edge conflict with a commit.

Test Plan:
1. mult rs=0xFFFFFFFE (-2), rt=3, start at T -> busy=1 for T+1..T+5; at T+6 hi=0xFFFFFFFF, lo=0xFFFFFFFA; op=5 then gives md_out=0xFFFFFFFF.
2. multu rs=0xFFFFFFFF, rt=0xFFFFFFFF -> after 5 busy cycles hi=0xFFFFFFFE, lo=0x00000001.
3. div rs=-7 (0xFFFFFFF9), rt=2 -> busy for 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu with rt=0 and prior hi=0x11, lo=0x22 -> busy 10 cycles, hi/lo stay 0x11/0x22.
4. Stall: issue mult with d_is_md=1 held -> stall_req=1 in the issue cycle and all busy cycles, 0 in the first cycle with busy=0. With d_is_md=0 throughout -> stall_req=0 throughout.
5. Hazards:
   - mthi rs=0xAAAA5555 -> hi=0xAAAA5555 next cycle, busy stays 0.
   - start(op=1) during RUN -> ignored, ovr_err=1, original result still commits on schedule.
6. Reset mid-div: reset=0 at the 4th busy cycle -> next cycle busy=0, hi=lo=0, ovr_err=0, and no later commit occurs.
